sram_arbiter: RTL and testbench

Shares the single external SRAM controller (sramc) between two requesters.
- Port A: CPU memory stage (load/store). Has priority.
- Port B: loader/IO DMA path (program/data upload).
- Sits between the requesters and sramc, driving sramc's memory_write/memory_address/memory_write_enable and routing memory_read back to the requester that issued the read.

---
 rtl/sram_arbiter.sv | 95 +++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of sramc; A has priority over B.
// Optional SRAM_ARB_STARVE_EN forces a waiting B request through after STARVE_LIMIT denied cycles.
module sram_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [19:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [19:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  input  logic [31:0] memory_read,
  output logic [31:0] memory_write,
  output logic [19:0] memory_address,
  output logic        memory_write_enable
);

  logic force_b;

`ifdef SRAM_ARB_STARVE_EN
  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CW-1:0] starve_cnt;

  assign force_b = (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (b_req && !b_ack) begin
      if (!force_b) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  assign b_ack = reset & b_req & (~a_req | force_b);
  assign a_ack = reset & a_req & ~(force_b & b_req);

  // Address and data hold across idle cycles; only the write strobe drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memory_address      <= '0;
      memory_write        <= '0;
      memory_write_enable <= 1'b0;
    end else begin
      memory_write_enable <= 1'b0;
      if (a_ack) begin
        memory_address      <= a_addr;
        memory_write        <= a_wdata;
        memory_write_enable <= a_we;
      end else if (b_ack) begin
        memory_address      <= b_addr;
        memory_write        <= b_wdata;
        memory_write_enable <= b_we;
      end
    end
  end

  // Stage k of the tag pipe describes the command presented k cycles ago; port 1 = B.
  logic [READ_LATENCY:0] tag_valid;
  logic [READ_LATENCY:0] tag_port;
  logic                  push_valid;

  assign push_valid = (a_ack & ~a_we) | (b_ack & ~b_we);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid <= {tag_valid[READ_LATENCY-1:0], push_valid};
      tag_port  <= {tag_port[READ_LATENCY-1:0], b_ack};
    end
  end

  assign a_rvalid = tag_valid[READ_LATENCY] & ~tag_port[READ_LATENCY];
  assign b_rvalid = tag_valid[READ_LATENCY] & tag_port[READ_LATENCY];
  assign a_rdata  = memory_read;
  assign b_rdata  = memory_read;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized bench for sram_arbiter against a transaction-level model.
module tb_sram_arbiter;
  localparam int RL = 2;
  localparam int SL = 4;
`ifdef SRAM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req, a_we, a_ack, a_rvalid;
  logic [19:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_ack, b_rvalid;
  logic [19:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [31:0] memory_read, memory_write;
  logic [19:0] memory_address;
  logic        memory_write_enable;

  always #5 clk = ~clk;

  sram_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_enable(memory_write_enable)
  );

  // sramc stand-in: 32 words, data valid two cycles after the command is presented
  logic [31:0] sram [0:31];
  logic [31:0] s1;
  always @(posedge clk) begin
    if (memory_write_enable) sram[memory_address[4:0]] <= memory_write;
    s1          <= sram[memory_address[4:0]];
    memory_read <= s1;
  end

  typedef struct { logic we; logic [19:0] addr; logic [31:0] data; int delay; } cmd_t;
  typedef struct { int due; int port; logic [31:0] data; } rd_t;

  cmd_t        cbuf [2][64];
  int          head [2];
  int          tail [2];
  bit          pend [2];
  bit          acked [2];
  int          idle [2];
  cmd_t        cur [2];
  rd_t         rq[$];
  logic [31:0] refmem [0:31];
  int          checks = 0, failures = 0, cyc = 0, waited = 0;
  logic        rst_v = 1'b0;
  logic        exp_we = 1'b0;
  logic [19:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_cmd(input int p, input logic we, input logic [19:0] addr,
                          input logic [31:0] data, input int delay);
    cbuf[p][tail[p] % 64] = '{we, addr, data, delay};
    tail[p]++;
  endtask

  task automatic do_cycle();
    int   g;
    bit   force_b, ea, eb;
    rd_t  r;
    cmd_t c;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (acked[p]) pend[p] = 1'b0;
      if (!pend[p]) begin
        if (head[p] == tail[p]) idle[p] = 0;
        else if (idle[p] >= cbuf[p][head[p] % 64].delay) begin
          cur[p] = cbuf[p][head[p] % 64];
          head[p]++;
          pend[p] = 1'b1;
          idle[p] = 0;
        end else idle[p]++;
      end
    end
    reset   = rst_v;
    a_req   = pend[0]; a_we = cur[0].we; a_addr = cur[0].addr; a_wdata = cur[0].data;
    b_req   = pend[1]; b_we = cur[1].we; b_addr = cur[1].addr; b_wdata = cur[1].data;
    @(negedge clk);
    if (!rst_v) begin
      check_eq("rst_a_ack", a_ack, 0);
      check_eq("rst_b_ack", b_ack, 0);
      check_eq("rst_we", memory_write_enable, 0);
      check_eq("rst_addr", memory_address, 0);
      check_eq("rst_wdata", memory_write, 0);
      check_eq("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      rq.delete();
      waited = 0; exp_we = 1'b0; last_addr = '0; last_data = '0;
    end else begin
      force_b = STARVE_EN && (waited >= SL);
      if (pend[0] && !(force_b && pend[1])) g = 1;
      else if (pend[1]) g = 2;
      else g = 0;
      check_eq("a_ack", a_ack, (g == 1));
      check_eq("b_ack", b_ack, (g == 2));
      check_eq("mem_we", memory_write_enable, exp_we);
      check_eq("mem_addr", memory_address, last_addr);
      check_eq("mem_wdata", memory_write, last_data);
      ea = 1'b0; eb = 1'b0; r = '{0, 0, 0};
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.port == 0) ea = 1'b1; else eb = 1'b1;
      end
      check_eq("a_rvalid", a_rvalid, ea);
      check_eq("b_rvalid", b_rvalid, eb);
      if (ea) check_eq("a_rdata", a_rdata, r.data);
      if (eb) check_eq("b_rdata", b_rdata, r.data);
      exp_we = 1'b0;
      if (g != 0) begin
        c = cur[g-1];
        if (c.we) refmem[c.addr[4:0]] = c.data;
        else rq.push_back('{cyc + 1 + RL, g - 1, refmem[c.addr[4:0]]});
        exp_we = c.we; last_addr = c.addr; last_data = c.data;
      end
      waited = (pend[1] && g != 2) ? ((waited < SL) ? waited + 1 : SL) : 0;
    end
    acked[0] = a_ack;
    acked[1] = b_ack;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((head[0] != tail[0] || head[1] != tail[1] || pend[0] || pend[1]) && n < 400) begin
      do_cycle();
      n++;
    end
    check_eq("drain_timeout", (n < 400), 1);
    for (int i = 0; i < RL + 2; i++) do_cycle();
    check_eq("reads_outstanding", rq.size(), 0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      head[p] = 0; tail[p] = 0; pend[p] = 0; acked[p] = 0; idle[p] = 0;
      cur[p] = '{1'b0, 20'd0, 32'd0, 0};
    end
    for (int i = 0; i < 32; i++) refmem[i] = 32'hx;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    repeat (3) do_cycle();
    rst_v = 1'b1;

    // preload every word so all later reads have known contents
    for (int i = 0; i < 32; i++)
      push_cmd(0, 1'b1, 20'(i), (i < 4) ? 32'(100 + i) : (i == 20) ? 32'd9 :
               (i == 21) ? 32'd10 : $urandom, 0);
    drain();

    // write then read-back on consecutive cycles
    push_cmd(0, 1'b1, 20'd15, 32'd10, 0);
    push_cmd(0, 1'b0, 20'd15, 32'd0, 0);
    drain();

    // simultaneous requests: A first, B the next cycle
    push_cmd(0, 1'b0, 20'd20, 32'd0, 0);
    push_cmd(1, 1'b0, 20'd21, 32'd0, 0);
    drain();

    // interleaved A,B,A,B reads of addresses 0..3
    push_cmd(0, 1'b0, 20'd0, 32'd0, 0);
    push_cmd(1, 1'b0, 20'd1, 32'd0, 1);
    push_cmd(0, 1'b0, 20'd2, 32'd0, 1);
    push_cmd(1, 1'b0, 20'd3, 32'd0, 1);
    drain();

    // A saturates the port while B waits
    for (int i = 0; i < 20; i++) push_cmd(0, 1'b0, 20'($urandom_range(0, 31)), 32'd0, 0);
    push_cmd(1, 1'b0, 20'd21, 32'd0, 0);
    drain();

    // reset one cycle after a read is accepted, with B pending during reset
    push_cmd(0, 1'b0, 20'd2, 32'd0, 0);
    do_cycle();
    do_cycle();
    push_cmd(1, 1'b0, 20'd5, 32'd0, 0);
    rst_v = 1'b0;
    do_cycle();
    rst_v = 1'b1;
    push_cmd(0, 1'b0, 20'd3, 32'd0, 0);
    drain();

    // random mixed traffic from both ports
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 2) == 0 && (tail[p] - head[p]) < 6)
          push_cmd(p, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 2));
      do_cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
